// File: rtl/tile_cfg_pkg.sv
// Shared config definitions for fabric tiles: op and FSM enums, config word
// layout as a function of N_IN, and field extract helpers.
package tile_cfg_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_L = 3'd6,
    OP_PASS_R = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_UNCONF         = 2'd0,
    ST_PENDING        = 2'd1,
    ST_ACTIVE         = 2'd2,
    ST_ACTIVE_PENDING = 2'd3
  } cfg_state_e;

  // Low nibble of every config word: op[3] then reg_mode[1].
  typedef struct packed {
    op_e  op;
    logic reg_mode;
  } cfg_lo_t;

  localparam int RMODE_LSB = 0;
  localparam int OP_LSB    = 1;
  localparam int RSEL_LSB  = 4;

  function automatic int sel_w(input int n_in);
    return $clog2(n_in);
  endfunction

  function automatic int cfg_w(input int n_in);
    return 2 * sel_w(n_in) + 4;
  endfunction

  function automatic int lsel_lsb(input int n_in);
    return RSEL_LSB + sel_w(n_in);
  endfunction

  function automatic cfg_lo_t cfg_lo(input logic [3:0] lo);
    return cfg_lo_t'(lo);
  endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// Double-buffered config register: addressed writes land in a shadow, a
// global commit strobe moves the shadow into the active copy.
module cfg_shadow_reg
  import tile_cfg_pkg::*;
#(
  parameter int CFG_W   = 10,
  parameter int ADDR_W  = 6,
  parameter int ADDRESS = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [CFG_W-1:0]  wr_data_i,
  input  logic              commit_i,
  output logic              ack_o,
  output logic              configured_o,
  output logic [CFG_W-1:0]  active_o
);

  cfg_state_e       state_q, state_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] active_q, active_d;
  logic             shadow_valid_q, shadow_valid_d;
  logic             ack_q;
  logic             hit, do_commit;

  assign hit       = wr_en_i && (wr_addr_i == ADDR_W'(ADDRESS));
  // Commit without a valid shadow changes nothing.
  assign do_commit = commit_i && shadow_valid_q;

  // State and config registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_UNCONF;
      shadow_q       <= '0;
      active_q       <= '0;
      shadow_valid_q <= 1'b0;
      ack_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      shadow_valid_q <= shadow_valid_d;
      ack_q          <= hit;
    end
  end

  // Next state: a same-edge write refills the shadow after commit drains it.
  always_comb begin
    state_d        = state_q;
    shadow_d       = hit ? wr_data_i : shadow_q;
    active_d       = do_commit ? shadow_q : active_q;
    shadow_valid_d = hit ? 1'b1 : (do_commit ? 1'b0 : shadow_valid_q);
    unique case (state_q)
      ST_UNCONF:         if (hit) state_d = ST_PENDING;
      ST_PENDING:        if (do_commit) state_d = hit ? ST_ACTIVE_PENDING : ST_ACTIVE;
      ST_ACTIVE:         if (hit) state_d = ST_ACTIVE_PENDING;
      ST_ACTIVE_PENDING: if (do_commit && !hit) state_d = ST_ACTIVE;
      default:           state_d = ST_UNCONF;
    endcase
  end

  assign ack_o        = ack_q;
  assign configured_o = (state_q == ST_ACTIVE) || (state_q == ST_ACTIVE_PENDING);
  assign active_o     = active_q;

endmodule

// File: rtl/compute_block_p.sv
// Reconfigurable logic tile: picks one bit from each routing bus, applies a
// two-input op, and drives the result either directly or through out_q.
module compute_block_p
  import tile_cfg_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int ADDR_W  = 6,
  parameter int ADDRESS = 0,
  localparam int SEL_W  = sel_w(N_IN),
  localparam int CFG_W  = cfg_w(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   left_in,
  input  logic [N_IN-1:0]   right_in,
  input  logic              config_en,
  input  logic [ADDR_W-1:0] config_addr,
  input  logic [CFG_W-1:0]  config_data,
  input  logic              config_commit,
  input  logic              ce,
  output logic              config_ack,
  output logic              configured,
  output logic [CFG_W-1:0]  cfg_active,
  output logic              out
);

  localparam int LSEL_LSB = lsel_lsb(N_IN);

  logic [CFG_W-1:0] active;
  logic [SEL_W-1:0] lsel, rsel;
  cfg_lo_t          lo;
  logic             a, b, f;
  logic             out_q;

  cfg_shadow_reg #(
    .CFG_W   (CFG_W),
    .ADDR_W  (ADDR_W),
    .ADDRESS (ADDRESS)
  ) u_cfg (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_en_i      (config_en),
    .wr_addr_i    (config_addr),
    .wr_data_i    (config_data),
    .commit_i     (config_commit),
    .ack_o        (config_ack),
    .configured_o (configured),
    .active_o     (active)
  );

  assign lsel = active[LSEL_LSB +: SEL_W];
  assign rsel = active[RSEL_LSB +: SEL_W];
  assign lo   = cfg_lo(active[3:0]);
  assign a    = left_in[lsel];
  assign b    = right_in[rsel];

  // Two-input logic function selected by the active op.
  always_comb begin
    f = 1'b0;
    unique case (lo.op)
      OP_AND:    f = a & b;
      OP_OR:     f = a | b;
      OP_XOR:    f = a ^ b;
      OP_NAND:   f = ~(a & b);
      OP_NOR:    f = ~(a | b);
      OP_XNOR:   f = ~(a ^ b);
      OP_PASS_L: f = a;
      OP_PASS_R: f = b;
      default:   f = 1'b0;
    endcase
  end

  // Output register runs in both modes so a mode switch never glitches it to 0;
  // it is pinned low until a config is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          out_q <= 1'b0;
    else if (!configured) out_q <= 1'b0;
    else if (ce)          out_q <= f;
  end

  assign out        = configured & (lo.reg_mode ? out_q : f);
  assign cfg_active = active;

endmodule

// File: tb/tb_compute_block_p.sv
// Directed bench for compute_block_p (N_IN=8, ADDRESS=0): config handshake,
// double buffering, op evaluation, reg/comb output modes, reset behaviour.
module tb_compute_block_p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] left_in, right_in;
  logic       config_en;
  logic [5:0] config_addr;
  logic [9:0] config_data;
  logic       config_commit;
  logic       ce;
  logic       config_ack;
  logic       configured;
  logic [9:0] cfg_active;
  logic       out;

  int n_cmp = 0;
  int n_err = 0;

  compute_block_p #(.N_IN(8), .ADDR_W(6), .ADDRESS(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .left_in       (left_in),
    .right_in      (right_in),
    .config_en     (config_en),
    .config_addr   (config_addr),
    .config_data   (config_data),
    .config_commit (config_commit),
    .ce            (ce),
    .config_ack    (config_ack),
    .configured    (configured),
    .cfg_active    (cfg_active),
    .out           (out)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] mk(input int l, input int r, input int op, input int rm);
    logic [9:0] w;
    w = {l[2:0], r[2:0], op[2:0], rm[0]};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] w1, w2;
    rst_n = 1'b0; left_in = '0; right_in = '0; config_en = 1'b0;
    config_addr = '0; config_data = '0; config_commit = 1'b0; ce = 1'b0;
    #2;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_configured", 32'(configured), 32'd0);
    chk("rst_cfg_active", 32'(cfg_active), 32'd0);
    chk("rst_ack", 32'(config_ack), 32'd0);
    #10 rst_n = 1'b1;

    // Unconfigured: inputs do not reach out.
    left_in = 8'hFF; right_in = 8'hFF; ce = 1'b1;
    tick(); tick();
    chk("unconf_out", 32'(out), 32'd0);
    chk("unconf_configured", 32'(configured), 32'd0);
    left_in = 8'hAA; right_in = 8'h55; #1;
    chk("unconf_out2", 32'(out), 32'd0);
    chk("unconf_cfg_active", 32'(cfg_active), 32'd0);

    // XOR comb, left_sel=3 right_sel=5.
    left_in = '0; right_in = '0;
    config_en = 1'b1; config_data = mk(3, 5, 2, 0);
    tick();
    config_en = 1'b0;
    chk("xor_ack", 32'(config_ack), 32'd1);
    chk("pending_configured", 32'(configured), 32'd0);
    chk("pending_out", 32'(out), 32'd0);
    config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
    chk("xor_ack_once", 32'(config_ack), 32'd0);
    chk("xor_configured", 32'(configured), 32'd1);
    chk("xor_cfg_active", 32'(cfg_active), 32'(mk(3, 5, 2, 0)));
    left_in = 8'b0000_1000; right_in = 8'b0010_0000; #1;
    chk("xor_11", 32'(out), 32'd0);
    right_in = 8'b0000_0000; #1;
    chk("xor_10", 32'(out), 32'd1);

    // AND active, OR only in shadow, then commit.
    config_en = 1'b1; config_data = mk(3, 5, 0, 0);
    tick();
    config_en = 1'b0; config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
    chk("and_out", 32'(out), 32'd0);
    config_en = 1'b1; config_data = mk(3, 5, 1, 0);
    tick();
    config_en = 1'b0;
    chk("or_shadow_out", 32'(out), 32'd0);
    chk("or_shadow_active", 32'(cfg_active), 32'(mk(3, 5, 0, 0)));
    config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
    chk("or_commit_out", 32'(out), 32'd1);
    chk("or_commit_active", 32'(cfg_active), 32'(mk(3, 5, 1, 0)));
    tick(); // out_q captures OR result (1) with ce=1

    // PASS_L reg mode on left_sel=2, ce held low.
    ce = 1'b0;
    config_en = 1'b1; config_data = mk(2, 0, 6, 1);
    tick();
    config_en = 1'b0; config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
    chk("reg_hold_init", 32'(out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      left_in[2] = ~left_in[2];
      tick();
      chk("reg_hold_ce0", 32'(out), 32'd1);
    end
    left_in[2] = 1'b0; ce = 1'b1; #1;
    chk("reg_before_edge", 32'(out), 32'd1);
    tick();
    chk("reg_after_edge0", 32'(out), 32'd0);
    left_in[2] = 1'b1; #1;
    chk("reg_latency", 32'(out), 32'd0);
    tick();
    chk("reg_after_edge1", 32'(out), 32'd1);

    // Same-edge write + commit with a pending shadow.
    w1 = mk(1, 1, 0, 0);
    w2 = mk(4, 6, 2, 0);
    config_en = 1'b1; config_data = w1;
    tick();
    config_data = w2; config_commit = 1'b1;
    tick();
    config_en = 1'b0; config_commit = 1'b0;
    chk("wc_active_old", 32'(cfg_active), 32'(w1));
    chk("wc_ack", 32'(config_ack), 32'd1);
    chk("wc_configured", 32'(configured), 32'd1);
    config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
    chk("wc_active_new", 32'(cfg_active), 32'(w2));
    chk("wc_ack_low", 32'(config_ack), 32'd0);
    left_in = 8'b0001_0000; right_in = 8'b0000_0000; #1;
    chk("w2_xor_10", 32'(out), 32'd1);
    right_in = 8'b0100_0000; #1;
    chk("w2_xor_11", 32'(out), 32'd0);

    // Write to another tile's address.
    config_en = 1'b1; config_addr = 6'd1; config_data = mk(0, 0, 7, 1);
    tick();
    config_en = 1'b0; config_addr = 6'd0;
    chk("miss_ack", 32'(config_ack), 32'd0);
    config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
    chk("miss_active", 32'(cfg_active), 32'(w2));
    chk("miss_configured", 32'(configured), 32'd1);

    // Async reset with a shadow pending: pending word must be lost.
    right_in = '0;
    config_en = 1'b1; config_data = mk(0, 0, 1, 0);
    tick();
    config_en = 1'b0;
    chk("pre_rst_out", 32'(out), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_configured", 32'(configured), 32'd0);
    chk("arst_active", 32'(cfg_active), 32'd0);
    chk("arst_ack", 32'(config_ack), 32'd0);
    #2 rst_n = 1'b1;
    config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
    chk("lost_configured", 32'(configured), 32'd0);
    chk("lost_active", 32'(cfg_active), 32'd0);

    // Reset in PENDING.
    left_in = 8'hFF; right_in = 8'h00;
    config_en = 1'b1; config_data = mk(3, 5, 2, 0);
    tick();
    config_en = 1'b0;
    chk("p_ack", 32'(config_ack), 32'd1);
    chk("p_out", 32'(out), 32'd0);
    #2 rst_n = 1'b0; #1;
    chk("p_arst_ack", 32'(config_ack), 32'd0);
    #2 rst_n = 1'b1;
    config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
    chk("p_lost_configured", 32'(configured), 32'd0);
    chk("p_lost_out", 32'(out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
